// File: rtl/ms_ff_bank_ctrl.sv
// ms_ff_bank_ctrl
// Sequencing controller and two-port round-robin arbiter for a bank of WIDTH
// master-slave SR flip-flops. Each accepted command is turned into a
// two-phase C pulse on the bank. The controller then reads Q back and
// reports completion and mismatch to the requester it served.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req0/op0/sel0   requester 0 command (op: 00 read, 01 set, 10 reset, 11 toggle)
//   req1/op1/sel1   requester 1 command
//   gnt0, gnt1      one-cycle completion pulse to the served requester
//   ff_S, ff_R      per-bit S/R inputs to the bank (never both high on a bit)
//   ff_C            shared C input to the bank
//   ff_Q            Q readback from the bank
//   rdata           Q snapshot taken on entry to CHECK, valid while gnt0|gnt1
//   err             high with gnt when the readback differs from the expected value
//   busy            high in every state except IDLE
//
// Handshake: a requester raises req with stable op/sel and holds req until
// its gnt pulse. op/sel are captured on the accept edge and ignored after it.
// A req still high after gnt counts as a new request.
module ms_ff_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] sel0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] sel1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] ff_S,
  output logic [WIDTH-1:0] ff_R,
  output logic             ff_C,
  input  logic [WIDTH-1:0] ff_Q,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    MASTER = 3'd2,
    SLAVE  = 3'd3,
    CHECK  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(HOLD - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             last1;    // 1: requester 1 was served last
  logic             owner1;   // 1: current command belongs to requester 1
  logic [WIDTH-1:0] exp_val;

  logic             pick1;
  logic [1:0]       op_w;
  logic [WIDTH-1:0] sel_w;
  logic [WIDTH-1:0] s_w;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] e_w;
  logic             phase_done;

  // Winner selection and S/R/expected encoding. These only feed registers.
  // Toggle drives S only on bits that read 0 and R only on bits that read 1,
  // so S and R never overlap on any bit.
  always_comb begin
    pick1 = req1 & (~req0 | ~last1);
    op_w  = pick1 ? op1  : op0;
    sel_w = pick1 ? sel1 : sel0;
    s_w   = '0;
    r_w   = '0;
    e_w   = ff_Q;
    case (op_w)
      2'b01: begin
        s_w = sel_w;
        e_w = ff_Q | sel_w;
      end
      2'b10: begin
        r_w = sel_w;
        e_w = ff_Q & ~sel_w;
      end
      2'b11: begin
        s_w = sel_w & ~ff_Q;
        r_w = sel_w & ff_Q;
        e_w = ff_Q ^ sel_w;
      end
      default: begin
        s_w = '0;
        r_w = '0;
        e_w = ff_Q;
      end
    endcase
  end

  assign phase_done = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last1   <= 1'b1;   // requester 0 wins the first contention
      owner1  <= 1'b0;
      exp_val <= '0;
      ff_S    <= '0;
      ff_R    <= '0;
      ff_C    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner1  <= pick1;
            last1   <= pick1;
            ff_S    <= s_w;
            ff_R    <= r_w;
            exp_val <= e_w;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (phase_done) begin
            cnt   <= '0;
            ff_C  <= 1'b1;
            state <= MASTER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        MASTER: begin
          // S/R are released together with C falling; the master closes
          // on that same edge, so nothing it holds is disturbed.
          if (phase_done) begin
            cnt   <= '0;
            ff_C  <= 1'b0;
            ff_S  <= '0;
            ff_R  <= '0;
            state <= SLAVE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SLAVE: begin
          if (phase_done) begin
            cnt   <= '0;
            rdata <= ff_Q;
            err   <= (ff_Q != exp_val);
            gnt0  <= ~owner1;
            gnt1  <= owner1;
            state <= CHECK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CHECK: begin
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ff_C  <= 1'b0;
          ff_S  <= '0;
          ff_R  <= '0;
        end
      endcase
    end
  end

endmodule
